if_id_stage: RTL

IF/ID pipeline stage of the MIPS-style datapath. It accepts fetched instruction words and their PCs over a valid/ready handshake and registers them through a 2-entry skid buffer. It splits each instruction into fields and presents them to decode. Its out_imm16 output is the 16-bit immediate that feeds the sign-extension stage directly downstream.

---
 rtl/mips_pkg.sv | 44 ++++
 rtl/instr_field_split.sv | 31 +++
 rtl/if_id_stage.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, instruction format encodings and
// field bit positions. The sign extender and later decode stages import these.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  // Instruction format as seen by decode; encoding 3 is never produced.
  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_J = 2'd2
  } fmt_e;

  localparam int OPCODE_MSB  = 31;
  localparam int OPCODE_LSB  = 26;
  localparam int RS_MSB      = 25;
  localparam int RS_LSB      = 21;
  localparam int RT_MSB      = 20;
  localparam int RT_LSB      = 16;
  localparam int RD_MSB      = 15;
  localparam int RD_LSB      = 11;
  localparam int SHAMT_MSB   = 10;
  localparam int SHAMT_LSB   = 6;
  localparam int FUNCT_MSB   = 5;
  localparam int FUNCT_LSB   = 0;
  localparam int IMM_MSB     = 15;
  localparam int IMM_LSB     = 0;
  localparam int JTARGET_MSB = 25;
  localparam int JTARGET_LSB = 0;

  // Opcode 0 is R-type, j/jal are J-type, everything else is treated as I-type.
  function automatic fmt_e decodeFmt(input logic [5:0] opcode);
    fmt_e fmt;
    case (opcode)
      OP_RTYPE:     fmt = FMT_R;
      OP_J, OP_JAL: fmt = FMT_J;
      default:      fmt = FMT_I;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// Purely combinational splitter: one 32-bit MIPS word in, every decode field
// plus the instruction format out. No state lives here.
module instr_field_split
  import mips_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  shamt_o,
  output logic [5:0]  funct_o,
  output logic [15:0] imm16_o,
  output logic [25:0] jtarget_o,
  output fmt_e        fmt_o
);

  // Slice the word into its overlapping fields and classify the format.
  always_comb begin
    opcode_o  = instr_i[OPCODE_MSB:OPCODE_LSB];
    rs_o      = instr_i[RS_MSB:RS_LSB];
    rt_o      = instr_i[RT_MSB:RT_LSB];
    rd_o      = instr_i[RD_MSB:RD_LSB];
    shamt_o   = instr_i[SHAMT_MSB:SHAMT_LSB];
    funct_o   = instr_i[FUNCT_MSB:FUNCT_LSB];
    imm16_o   = instr_i[IMM_MSB:IMM_LSB];
    jtarget_o = instr_i[JTARGET_MSB:JTARGET_LSB];
    fmt_o     = decodeFmt(instr_i[OPCODE_MSB:OPCODE_LSB]);
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register built as a 2-entry skid buffer. The main slot feeds
// decode; the skid slot catches one extra word so in_ready can be a pure flop
// output with no combinational path back from out_ready.
module if_id_stage
  import mips_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_pc_plus4,
  output logic [5:0]         out_opcode,
  output logic [4:0]         out_rs,
  output logic [4:0]         out_rt,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_shamt,
  output logic [5:0]         out_funct,
  output logic [15:0]        out_imm16,
  output logic [25:0]        out_jtarget,
  output logic [1:0]         out_fmt
);

  // The field splitter only understands 32-bit MIPS words.
  if (INSTR_W != 32) begin : gBadInstrWidth
    $error("if_id_stage: INSTR_W must be 32");
  end

  logic               mainValid_q, mainValid_d;
  logic [INSTR_W-1:0] mainInstr_q, mainInstr_d;
  logic [PC_W-1:0]    mainPc_q,    mainPc_d;
  logic               skidValid_q, skidValid_d;
  logic [INSTR_W-1:0] skidInstr_q, skidInstr_d;
  logic [PC_W-1:0]    skidPc_q,    skidPc_d;
  logic               inFire;
  fmt_e               fmt;

  assign in_ready  = ~skidValid_q;
  assign inFire    = in_valid & in_ready;
  assign out_valid = mainValid_q;

  // Next-state for both slots: flush wins, skid drains before new input, and
  // the skid only fills when main is stalled and a word still arrives.
  always_comb begin
    mainValid_d = mainValid_q;
    mainInstr_d = mainInstr_q;
    mainPc_d    = mainPc_q;
    skidValid_d = skidValid_q;
    skidInstr_d = skidInstr_q;
    skidPc_d    = skidPc_q;
    if (flush) begin
      mainValid_d = 1'b0;
      skidValid_d = 1'b0;
    end else begin
      if (!mainValid_q || out_ready) begin
        if (skidValid_q) begin
          mainValid_d = 1'b1;
          mainInstr_d = skidInstr_q;
          mainPc_d    = skidPc_q;
          skidValid_d = 1'b0;
        end else if (inFire) begin
          mainValid_d = 1'b1;
          mainInstr_d = in_instr;
          mainPc_d    = in_pc;
        end else begin
          mainValid_d = 1'b0;
        end
      end
      if (mainValid_q && !out_ready && inFire) begin
        skidValid_d = 1'b1;
        skidInstr_d = in_instr;
        skidPc_d    = in_pc;
      end
    end
  end

  // Slot registers; async reset clears data too so decode sees an all-zero word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mainValid_q <= 1'b0;
      mainInstr_q <= '0;
      mainPc_q    <= '0;
      skidValid_q <= 1'b0;
      skidInstr_q <= '0;
      skidPc_q    <= '0;
    end else begin
      mainValid_q <= mainValid_d;
      mainInstr_q <= mainInstr_d;
      mainPc_q    <= mainPc_d;
      skidValid_q <= skidValid_d;
      skidInstr_q <= skidInstr_d;
      skidPc_q    <= skidPc_d;
    end
  end

  assign out_pc       = mainPc_q;
  assign out_pc_plus4 = mainPc_q + PC_W'(4);
  assign out_fmt      = fmt;

  instr_field_split uSplit (
    .instr_i   (mainInstr_q),
    .opcode_o  (out_opcode),
    .rs_o      (out_rs),
    .rt_o      (out_rt),
    .rd_o      (out_rd),
    .shamt_o   (out_shamt),
    .funct_o   (out_funct),
    .imm16_o   (out_imm16),
    .jtarget_o (out_jtarget),
    .fmt_o     (fmt)
  );

endmodule
